// File: rtl/booth_fir_seq_if.sv
// ============================================================================
// booth_fir_seq_if : sample/result handshakes, coefficient port, multiplier link
// Revision: 1.0
// ============================================================================
`default_nettype none

interface booth_fir_seq_if #(
  parameter int ACC_W = 12,
  parameter int AW    = 2
);
  logic             coef_we;
  logic [AW-1:0]    coef_addr;
  logic [3:0]       coef_data;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_sample;
  logic [3:0]       mul_md;
  logic [3:0]       mul_mr;
  logic [7:0]       mul_prod;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;

  modport slave (
    input  coef_we, coef_addr, coef_data,
    input  in_valid, in_sample,
    output in_ready,
    output mul_md, mul_mr,
    input  mul_prod,
    output out_valid, out_data,
    input  out_ready
  );

  modport master (
    output coef_we, coef_addr, coef_data,
    output in_valid, in_sample,
    input  in_ready,
    input  mul_md, mul_mr,
    output mul_prod,
    input  out_valid, out_data,
    output out_ready
  );
endinterface

`default_nettype wire

// File: rtl/booth_fir_seq.sv
// ============================================================================
// booth_fir_seq : sequential FIR, one tap per cycle through an external
//                 combinational 4x4 signed Booth multiplier
// Revision: 1.0
// ============================================================================
`default_nettype none

module booth_fir_seq #(
  parameter int TAPS  = 4,
  parameter int ACC_W = 12,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  booth_fir_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       x_q    [TAPS];
  logic [3:0]       x_d    [TAPS];
  logic [3:0]       coef_q [TAPS];
  logic [3:0]       coef_d [TAPS];
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [AW-1:0]    idx_q, idx_d;

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] acc_sum;

  assign prod_ext = {{(ACC_W-8){bus.mul_prod[7]}}, bus.mul_prod};
  assign acc_sum  = acc_q + prod_ext;

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.mul_md    = (state_q == S_MAC) ? coef_q[idx_q] : 4'd0;
  assign bus.mul_mr    = (state_q == S_MAC) ? x_q[idx_q]    : 4'd0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    coef_d      = coef_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    idx_d       = idx_q;

    case (state_q)
      S_IDLE: begin
        // Coefficient write lands at the same edge as an acceptance, so the
        // MAC that follows already sees the new value.
        if (bus.coef_we) begin
          coef_d[bus.coef_addr] = bus.coef_data;
        end
        if (bus.in_valid) begin
          for (int k = 1; k < TAPS; k++) begin
            x_d[k] = x_q[k-1];
          end
          x_d[0]  = bus.in_sample;
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_sum;
        idx_d = idx_q + AW'(1);
        if (idx_q == AW'(TAPS-1)) begin
          out_data_d  = acc_sum;
          out_valid_d = 1'b1;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      idx_q       <= '0;
      for (int k = 0; k < TAPS; k++) begin
        x_q[k]    <= 4'd0;
        coef_q[k] <= 4'd0;
      end
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      idx_q       <= idx_d;
      for (int k = 0; k < TAPS; k++) begin
        x_q[k]    <= x_d[k];
        coef_q[k] <= coef_d[k];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_booth_fir_seq.sv
// ============================================================================
// tb_booth_fir_seq : directed bench for booth_fir_seq with a behavioural multiplier
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_booth_fir_seq;

  localparam int TAPS  = 4;
  localparam int ACC_W = 12;
  localparam int AW    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  booth_fir_seq_if #(.ACC_W(ACC_W), .AW(AW)) bus ();

  booth_fir_seq #(.TAPS(TAPS), .ACC_W(ACC_W), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Combinational signed 4x4 multiplier: low 8 bits of the sign-extended product.
  logic [7:0] md_ext, mr_ext, prod_full;
  assign md_ext       = {{4{bus.mul_md[3]}}, bus.mul_md};
  assign mr_ext       = {{4{bus.mul_mr[3]}}, bus.mul_mr};
  assign prod_full    = md_ext * mr_ext;
  assign bus.mul_prod = prod_full;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic        do_rst;
    logic        load;
    logic [15:0] coefs;   // {c3, c2, c1, c0}
    logic [3:0]  s;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    chk({nm, "_idle_timeout"}, int'(bus.in_ready), 1);
  endtask

  task automatic write_coef(input logic [1:0] a, input logic [3:0] d);
    wait_idle("coef");
    bus.coef_we   = 1'b1;
    bus.coef_addr = a;
    bus.coef_data = d;
    tick();
    bus.coef_we   = 1'b0;
  endtask

  task automatic load_coefs(input logic [15:0] c);
    for (int i = 0; i < TAPS; i++) begin
      write_coef(2'(i), c[4*i +: 4]);
    end
  endtask

  // Returns one cycle after the accepting edge (first MAC cycle, idx 0).
  task automatic accept(input string nm, input logic [3:0] s,
                        input bit we, input logic [1:0] a, input logic [3:0] d);
    wait_idle(nm);
    bus.in_valid  = 1'b1;
    bus.in_sample = s;
    bus.coef_we   = we;
    bus.coef_addr = a;
    bus.coef_data = d;
    tick();
    bus.in_valid  = 1'b0;
    bus.coef_we   = 1'b0;
    chk({nm, "_busy"}, int'(bus.in_ready), 0);
    chk({nm, "_mr0"}, int'(bus.mul_mr), int'(s));
  endtask

  task automatic wait_result(input string nm, input int exp, input int n0);
    int n = n0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({nm, "_latency"}, n, TAPS);
    chk({nm, "_data"}, int'($signed(bus.out_data)), exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    logic [ACC_W-1:0] held;

    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    bus.in_valid  = 1'b0;
    bus.in_sample = '0;
    bus.out_ready = 1'b1;

    tbl[0] = '{1'b1, 1'b1, 16'h4321, 4'd1,  12'd1};
    tbl[1] = '{1'b0, 1'b0, 16'h0000, 4'd2,  12'd4};
    tbl[2] = '{1'b0, 1'b0, 16'h0000, 4'd3,  12'd10};
    tbl[3] = '{1'b0, 1'b0, 16'h0000, 4'd4,  12'd20};
    tbl[4] = '{1'b1, 1'b1, 16'h8888, 4'h8,  12'd64};
    tbl[5] = '{1'b0, 1'b0, 16'h0000, 4'h8,  12'd128};
    tbl[6] = '{1'b0, 1'b0, 16'h0000, 4'h8,  12'd192};
    tbl[7] = '{1'b0, 1'b0, 16'h0000, 4'h8,  12'h100};
    tbl[8] = '{1'b1, 1'b1, 16'hF1F1, 4'd7,  12'd7};
    tbl[9] = '{1'b0, 1'b0, 16'h0000, 4'h8,  12'hFF1};

    tick();
    pulse_reset();
    chk("rst_in_ready",  int'(bus.in_ready),  1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_data",  int'(bus.out_data),  0);
    chk("rst_mul_md",    int'(bus.mul_md),    0);
    chk("rst_mul_mr",    int'(bus.mul_mr),    0);

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].do_rst) pulse_reset();
      if (tbl[i].load)   load_coefs(tbl[i].coefs);
      accept($sformatf("vec%0d", i), tbl[i].s, 1'b0, 2'd0, 4'd0);
      wait_result($sformatf("vec%0d", i), int'($signed(tbl[i].exp)), 0);
    end

    // Backpressure: delay line is {-8,7,0,0}, coefs {1,-1,1,-1}.
    wait_idle("bp");
    bus.out_ready = 1'b0;
    accept("bp1", 4'd1, 1'b0, 2'd0, 4'd0);
    wait_result("bp1", 16, 0);
    held = bus.out_data;
    bus.in_valid  = 1'b1;
    bus.in_sample = 4'd2;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (!bus.out_valid || bus.out_data != held || bus.in_ready) bad++;
    end
    chk("bp_hold_stable", bad, 0);
    bus.out_ready = 1'b1;
    tick();
    chk("bp_release_valid", int'(bus.out_valid), 0);
    chk("bp_release_ready", int'(bus.in_ready),  1);
    chk("bp_idle_md",       int'(bus.mul_md),    0);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_accepted", int'(bus.in_ready), 0);
    wait_result("bp2", -14, 0);

    // Coefficient write while busy is ignored; same-edge write in IDLE is used.
    pulse_reset();
    load_coefs(16'h0001);
    accept("cw1", 4'd3, 1'b0, 2'd0, 4'd0);
    bus.coef_we   = 1'b1;
    bus.coef_addr = 2'd0;
    bus.coef_data = 4'd5;
    tick();
    bus.coef_we   = 1'b0;
    wait_result("cw1", 3, 1);
    accept("cw2", 4'd4, 1'b0, 2'd0, 4'd0);
    wait_result("cw2", 4, 0);
    accept("cw3", 4'd1, 1'b1, 2'd0, 4'd2);
    wait_result("cw3", 2, 0);

    // Reset during the second MAC cycle discards the partial result.
    accept("mr", 4'd5, 1'b0, 2'd0, 4'd0);
    tick();
    pulse_reset();
    chk("mr_in_ready",  int'(bus.in_ready),  1);
    chk("mr_out_valid", int'(bus.out_valid), 0);
    chk("mr_out_data",  int'(bus.out_data),  0);
    bad = 0;
    for (int c = 0; c < TAPS + 2; c++) begin
      tick();
      if (bus.out_valid) bad++;
    end
    chk("mr_no_output", bad, 0);
    load_coefs(16'h0002);
    accept("mr2", 4'd3, 1'b0, 2'd0, 4'd0);
    bad = 0;
    for (int c = 1; c < TAPS; c++) begin
      tick();
      if (bus.mul_mr != 4'd0) bad++;
    end
    chk("mr_delay_cleared", bad, 0);
    wait_result("mr2", 6, TAPS - 1);

    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
